// File: rtl/bus_mux.sv
// bus_mux: single-owner bus multiplexer between four masters and four slaves.
// A granted, strobing master is captured in IDLE; its address nibble [31:28]
// picks one of four slaves (0..3) or raises a decode error. The transfer then
// waits for the selected slave's ack, bounded by a TIMEOUT-cycle watchdog, and
// answers the owner with a one-cycle ack or error pulse.
//
// Ports
//   clk, rst                 : clock, asynchronous active-low reset
//   m_get[3:0], m_stb[3:0]   : arbiter grant vector, per-master request strobe
//   m_we, m_addr, m_wdata,
//   m_sel                    : per-master request fields, 32-bit lanes (4-bit for sel)
//   m_ack, m_err             : one-cycle completion / error pulse to the owner
//   m_rdata                  : registered read data shared by all masters
//   s_stb[3:0]               : one-hot strobe to the selected slave
//   s_we, s_addr, s_wdata,
//   s_sel                    : captured request broadcast to every slave
//   s_ack[3:0], s_rdata      : per-slave ack and 32-bit read data lanes
//
// state  | meaning
// IDLE   | waiting for a one-hot grant with the matching strobe
// ACCESS | strobing the selected slave, counting wait cycles
// DONE   | m_ack pulse to the owner
// ERROR  | m_err pulse to the owner, m_rdata holds ERR_RDATA

module bus_mux #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   m_get,
  input  logic [3:0]   m_stb,
  input  logic [3:0]   m_we,
  input  logic [127:0] m_addr,
  input  logic [127:0] m_wdata,
  input  logic [15:0]  m_sel,
  output logic [3:0]   m_ack,
  output logic [3:0]   m_err,
  output logic [31:0]  m_rdata,
  output logic [3:0]   s_stb,
  output logic         s_we,
  output logic [31:0]  s_addr,
  output logic [31:0]  s_wdata,
  output logic [3:0]   s_sel,
  input  logic [3:0]   s_ack,
  input  logic [127:0] s_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic [1:0]  owner_q;
  logic [1:0]  slave_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;

  logic        gnt_onehot;
  logic [1:0]  gnt_idx;
  logic        cap_en;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_sel;
  logic        cap_we;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Only an exactly one-hot grant whose master is also strobing is accepted;
  // zero or multi-hot grants leave the mux idle.
  always_comb begin
    gnt_onehot = (m_get != 4'd0) && ((m_get & (m_get - 4'd1)) == 4'd0);
    gnt_idx    = 2'd0;
    case (m_get)
      4'b0001: gnt_idx = 2'd0;
      4'b0010: gnt_idx = 2'd1;
      4'b0100: gnt_idx = 2'd2;
      4'b1000: gnt_idx = 2'd3;
      default: gnt_idx = 2'd0;
    endcase
    cap_en    = gnt_onehot && m_stb[gnt_idx];
    cap_addr  = m_addr[32*gnt_idx +: 32];
    cap_wdata = m_wdata[32*gnt_idx +: 32];
    cap_sel   = m_sel[4*gnt_idx +: 4];
    cap_we    = m_we[gnt_idx];
  end

  assign s_we    = we_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_sel   = sel_q;

  // m_ack, m_err and s_stb are registers, so no input reaches them
  // combinationally and reset clears them immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      owner_q <= 2'd0;
      slave_q <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      sel_q   <= 4'd0;
      m_ack   <= 4'd0;
      m_err   <= 4'd0;
      m_rdata <= 32'd0;
      s_stb   <= 4'd0;
    end else begin
      m_ack <= 4'd0;
      m_err <= 4'd0;
      case (state_q)
        IDLE: begin
          if (cap_en) begin
            owner_q <= gnt_idx;
            addr_q  <= cap_addr;
            wdata_q <= cap_wdata;
            sel_q   <= cap_sel;
            we_q    <= cap_we;
            cnt_q   <= 8'd0;
            if (cap_addr[31:30] == 2'b00) begin
              slave_q <= cap_addr[29:28];
              s_stb   <= onehot4(cap_addr[29:28]);
              state_q <= ACCESS;
            end else begin
              m_err   <= onehot4(gnt_idx);
              m_rdata <= ERR_RDATA;
              state_q <= ERROR;
            end
          end
        end
        ACCESS: begin
          // Ack beats the timeout when both land in the same cycle.
          if (s_ack[slave_q]) begin
            s_stb   <= 4'd0;
            m_ack   <= onehot4(owner_q);
            if (!we_q) m_rdata <= s_rdata[32*slave_q +: 32];
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            s_stb   <= 4'd0;
            m_err   <= onehot4(owner_q);
            m_rdata <= ERR_RDATA;
            state_q <= ERROR;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        DONE:    state_q <= IDLE;
        ERROR:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_mux.sv
// Directed testbench for bus_mux. Stimulus tasks push the expected master
// response into a scoreboard queue; an independent monitor pops and compares
// whenever m_ack or m_err is asserted.

module tb_bus_mux;

  localparam int          TO   = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   m_get = '0, m_stb = '0, m_we = '0;
  logic [127:0] m_addr = '0, m_wdata = '0;
  logic [15:0]  m_sel = '0;
  logic [3:0]   m_ack, m_err, s_stb, s_sel;
  logic [31:0]  m_rdata, s_addr, s_wdata;
  logic         s_we;
  logic [3:0]   s_ack = '0;
  logic [127:0] s_rdata = '0;

  bus_mux #(.TIMEOUT(TO), .ERR_RDATA(ERRD)) dut (
    .clk(clk), .rst(rst),
    .m_get(m_get), .m_stb(m_stb), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_sel(m_sel),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata),
    .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_sel(s_sel), .s_ack(s_ack), .s_rdata(s_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [31:0] rdata;
  } resp_t;

  resp_t       sb_q[$];
  resp_t       mon_e;
  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] exp_rdata = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest expected entry.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && (m_ack != 4'd0 || m_err != 4'd0)) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_resp: got ack=%b err=%b, want no response (t=%0t)",
                   m_ack, m_err, $time);
        end else begin
          mon_e = sb_q.pop_front();
          check("resp_ack",   {28'd0, m_ack}, {28'd0, mon_e.ack});
          check("resp_err",   {28'd0, m_err}, {28'd0, mon_e.err});
          check("resp_rdata", m_rdata, mon_e.rdata);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog");
  end

  // One transaction from master mi. ack_after = number of wait cycles before
  // the slave acks (negative = never). After capture the grant/strobe lines
  // are replaced by after_get/after_stb and all addresses are scrambled to
  // prove the mux works from captured state only.
  task automatic run_txn(input int mi, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] sel,
                         input int ack_after, input logic [31:0] srd,
                         input logic [3:0] grant, input logic [3:0] after_get,
                         input logic [3:0] after_stb);
    logic [1:0] k;
    bit         ok;
    bit         acked;
    int         cyc;
    resp_t      e;
    k  = addr[29:28];
    ok = (addr[31:30] == 2'b00);
    m_get = grant;
    m_stb = 4'd0;
    m_stb[mi] = 1'b1;
    m_we[mi]  = we;
    m_addr[32*mi +: 32]  = addr;
    m_wdata[32*mi +: 32] = wdata;
    m_sel[4*mi +: 4]     = sel;
    e.ack = 4'd0;
    e.err = 4'd0;
    if (!ok || ack_after < 0 || ack_after >= TO) begin
      e.err = 4'b0001 << mi;
      exp_rdata = ERRD;
    end else begin
      e.ack = 4'b0001 << mi;
      if (!we) exp_rdata = srd;
    end
    e.rdata = exp_rdata;
    @(posedge clk);
    #1;
    sb_q.push_back(e);
    m_get  = after_get;
    m_stb  = after_stb;
    m_addr = {4{32'hF000_0000}};
    if (ok) begin
      cyc   = 0;
      acked = 0;
      while (!acked && cyc < TO) begin
        s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
        s_rdata[32*k +: 32] = srd;
        if (cyc == ack_after) begin
          s_ack = 4'b0001 << k;
          acked = 1;
        end else begin
          s_ack = ~(4'b0001 << k);
        end
        @(negedge clk);
        check("s_stb_on", {28'd0, s_stb}, {28'd0, 4'b0001 << k});
        if (cyc == 0) begin
          check("s_we",    {31'd0, s_we}, {31'd0, we});
          check("s_addr",  s_addr, addr);
          check("s_wdata", s_wdata, wdata);
          check("s_sel",   {28'd0, s_sel}, {28'd0, sel});
        end
        @(posedge clk);
        #1;
        s_ack = 4'd0;
        cyc++;
      end
    end
    m_get = 4'd0;
    m_stb = 4'd0;
    @(negedge clk);
    check("s_stb_off", {28'd0, s_stb}, 32'd0);
    check("resp_present", {31'd0, (m_ack | m_err) != 4'd0}, 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("pulse_len", {24'd0, m_ack, m_err}, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_m_ack",   {28'd0, m_ack}, 32'd0);
    check("rst_m_err",   {28'd0, m_err}, 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check("rst_s_stb",   {28'd0, s_stb}, 32'd0);
    check("rst_s_addr",  s_addr, 32'd0);
    #11;
    rst = 1'b1;
    @(negedge clk);

    // read, slave 1, immediate ack
    run_txn(1, 1'b0, 32'h1000_0040, 32'd0, 4'hF, 0, 32'hCAFE_F00D,
            4'b0010, 4'b0010, 4'b0000);
    // write, slave 3, three wait cycles; m_rdata keeps last read
    run_txn(0, 1'b1, 32'h3000_0000, 32'h1234_5678, 4'hF, 3, 32'h9999_9999,
            4'b0001, 4'b0000, 4'b0000);
    // decode error
    run_txn(2, 1'b0, 32'h7000_0000, 32'd0, 4'hF, 0, 32'd0,
            4'b0100, 4'b0000, 4'b0000);
    // timeout on slave 0
    run_txn(0, 1'b0, 32'h0000_0010, 32'd0, 4'h1, -1, 32'h4444_4444,
            4'b0001, 4'b0000, 4'b0000);
    // grant dropped mid-transaction, another master strobing meanwhile
    run_txn(3, 1'b0, 32'h2000_0004, 32'd0, 4'hF, 1, 32'h5A5A_1234,
            4'b1000, 4'b0000, 4'b0001);
    // grant switched to another strobing master during ACCESS
    run_txn(1, 1'b0, 32'h0000_0008, 32'd0, 4'h3, 2, 32'h7777_0000,
            4'b0010, 4'b0001, 4'b0001);
    // ack exactly on the last timeout cycle still wins
    run_txn(2, 1'b0, 32'h1000_0000, 32'd0, 4'hC, TO - 1, 32'h0F0F_0F0F,
            4'b0100, 4'b0000, 4'b0000);

    // multi-hot grant, then one-hot grant without matching strobe
    m_addr = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    m_get = 4'b0011;
    m_stb = 4'b0011;
    repeat (3) begin
      @(negedge clk);
      check("multihot_stb", {28'd0, s_stb}, 32'd0);
    end
    m_get = 4'b0100;
    m_stb = 4'b0001;
    repeat (2) begin
      @(negedge clk);
      check("nostb_stb", {28'd0, s_stb}, 32'd0);
    end
    m_get = 4'd0;
    m_stb = 4'd0;
    @(negedge clk);

    // reset asserted mid-ACCESS
    m_get = 4'b0100;
    m_stb = 4'b0100;
    m_we  = 4'd0;
    m_addr[95:64] = 32'h2000_0000;
    @(posedge clk);
    #1;
    m_get = 4'd0;
    m_stb = 4'd0;
    s_ack = 4'd0;
    @(negedge clk);
    check("rst_pre_stb", {28'd0, s_stb}, 32'h4);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rst_mid_stb",   {28'd0, s_stb}, 32'd0);
    check("rst_mid_rdata", m_rdata, 32'd0);
    check("rst_mid_resp",  {24'd0, m_ack, m_err}, 32'd0);
    exp_rdata = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_idle_stb", {28'd0, s_stb}, 32'd0);
    end

    // normal operation after reset
    run_txn(2, 1'b0, 32'h0000_0100, 32'd0, 4'hF, 2, 32'h0BB0_1234,
            4'b0100, 4'b0000, 4'b0000);

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bus_mux.md
BUS_MUX -- requirements
Module: bus_mux

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide parameter TIMEOUT, default 16: the maximum number of ACCESS cycles to wait for a slave ack (legal range 2..255).
REQ-002 SHALL provide parameter ERR_RDATA, default 32'h0000_0000: the value placed on m_rdata when a transaction ends in error.

Ports (name, direction, width, meaning):
REQ-003 SHALL provide clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL provide rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL provide m_get, input, 4: grant vector from the bus arbiter; bit i is master i's grant.
REQ-006 SHALL provide m_stb, input, 4: per-master request strobe.
REQ-007 SHALL provide m_we, input, 4: per-master write enable.
REQ-008 SHALL provide m_addr, input, 128: master i's address on bits [32i+31:32i].
REQ-009 SHALL provide m_wdata, input, 128: master i's write data on bits [32i+31:32i].
REQ-010 SHALL provide m_sel, input, 16: master i's byte selects on bits [4i+3:4i].
REQ-011 SHALL provide m_ack, output, 4: one-cycle completion pulse to the owning master.
REQ-012 SHALL provide m_err, output, 4: one-cycle error pulse to the owning master.
REQ-013 SHALL provide m_rdata, output, 32: registered read data, shared by all masters.
REQ-014 SHALL provide s_stb, output, 4: per-slave strobe, at most one bit high.
REQ-015 SHALL provide s_we (1), s_addr (32), s_wdata (32) and s_sel (4) as outputs broadcast to all slaves.
REQ-016 SHALL provide s_ack, input, 4: per-slave acknowledge.
REQ-017 SHALL provide s_rdata, input, 128: slave k's read data on bits [32k+31:32k].

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, DONE and ERROR.
REQ-019 In IDLE, capture SHALL occur only when m_get is exactly one-hot with index i and m_stb[i]=1.
  - Captured: owner=i, plus master i's addr, wdata, we and sel.
  - m_get zero or multi-hot: remain in IDLE, capture nothing.
REQ-020 Capture SHALL decode addr[31:28] to select the next state.
  - Values 0..3 select slave k; next state ACCESS.
  - Any other value: next state ERROR.
REQ-021 s_we, s_addr, s_wdata and s_sel SHALL always be driven from the captured registers.
REQ-022 In ACCESS, s_stb[k]=1 for the selected slave k and all other s_stb bits SHALL be 0.
REQ-023 In ACCESS, s_ack[k]=1 SHALL move the FSM to DONE; on a read, s_rdata slice k is loaded into m_rdata in the same edge.
  - On a write, m_rdata is left unchanged.
REQ-024 s_ack bits of non-selected slaves SHALL be ignored in every state.
REQ-025 The timeout counter SHALL clear on entering ACCESS and increment once per ACCESS cycle without ack.
  - When it reaches TIMEOUT-1 with no ack, next state is ERROR.
  - If ack arrives in that same cycle, ack wins (DONE).
REQ-026 In DONE, m_ack[owner]=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-027 In ERROR, m_err[owner]=1 for exactly one cycle and m_rdata loads ERR_RDATA, then the FSM SHALL return to IDLE.
REQ-028 Latency SHALL be as follows:
  - Capture at edge N: s_stb high during cycle N+1.
  - Slave ack in cycle N+1+j: m_ack high in cycle N+2+j.
  - Minimum request-to-ack latency: 2 cycles.
REQ-029 m_get and m_stb changes outside IDLE SHALL be ignored; a grant withdrawn mid-transaction still completes to the captured owner.
REQ-030 A master still holding m_stb and its grant in the cycle after DONE/ERROR SHALL be captured on the next IDLE edge (back-to-back, one idle cycle).
REQ-031 m_ack, m_err and s_stb SHALL be registered or decoded from state only, with no combinational path from any input.

Reset
REQ-032 rst=0 SHALL asynchronously force all of the following:
  - FSM state IDLE, counter 0, owner 0, captured registers 0.
  - All outputs 0, including m_rdata.
REQ-033 Reset asserted mid-ACCESS SHALL drop s_stb immediately, with no m_ack or m_err issued; after deassertion the block waits in IDLE for a new capture.

Verification
REQ-034 The bench SHALL cover these directed scenarios:
  - Read, slave 1, immediate ack: m_get=0010, m_stb[1]=1, m_addr[63:32]=0x1000_0040, s_rdata slice1=0xCAFE_F00D, s_ack[1] high in the first ACCESS cycle -> s_stb=0010 for 1 cycle, m_ack=0010 one cycle later, m_rdata=0xCAFE_F00D.
  - Write, slave 3, ack after 3 wait cycles: master 0 writes 0x3000_0000/0x1234_5678/sel=1111 -> s_we=1, s_wdata=0x1234_5678, s_stb=1000 for 4 cycles, m_ack=0001, m_rdata unchanged.
  - Decode error: master 2, address 0x7000_0000 -> no s_stb, m_err=0100 in the cycle after capture, m_rdata=ERR_RDATA.
  - Timeout: slave 0 never acks, TIMEOUT=16 -> s_stb=0001 for exactly 16 cycles, then m_err=0001 for 1 cycle, then IDLE.
  - Grant drop and reset: m_get drops to 0000 during ACCESS -> the transaction still acks the original owner; separately, rst=0 during ACCESS -> s_stb=0 immediately and no m_ack/m_err.
  - Multi-hot grant: m_get=0011 with both strobes high -> no capture, s_stb stays 0000.
